fft_trivial_twiddle_align: RTL

- Latency-matched bypass path for the untwiddled and trivially-twiddled branches of a radix-4 DIT butterfly, for LANES complex lanes.
- Applies an exact trivial rotation (×1, ×−j, ×−1, ×+j), then a left shift by SHIFT so the result has the scale of a real twiddle-multiplier product.
- Delays data, valid and sof by LATENCY cycles so outputs line up with the full complex-multiplier branches feeding the same butterfly adder.

---
 rtl/fft_trivial_twiddle_align.sv | 108 ++++++++++
 1 files changed

// File: rtl/fft_trivial_twiddle_align.sv
// Latency-matched bypass for the untwiddled / trivially-twiddled radix-4 DIT branches:
// exact rotation by 1, -j, -1 or +j, rescaled to multiplier-product scale, delayed LATENCY cycles.
module fft_trivial_twiddle_align #(
  parameter  int DATA_WIDTH = 21,
  parameter  int TWID_WIDTH = 16,
  parameter  int SHIFT      = 15,
  parameter  int LATENCY    = 4,
  parameter  int LANES      = 1,
  localparam int OUT_WIDTH  = DATA_WIDTH + TWID_WIDTH + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sclr,
  input  logic                          in_valid,
  input  logic                          in_sof,
  input  logic [1:0]                    rot,
  input  logic [LANES*DATA_WIDTH-1:0]   a_r,
  input  logic [LANES*DATA_WIDTH-1:0]   a_i,
  output logic                          out_valid,
  output logic                          out_sof,
  output logic [LANES*OUT_WIDTH-1:0]    b_r,
  output logic [LANES*OUT_WIDTH-1:0]    b_i,
  output logic                          busy
);

  // Handshake: valid-only streaming, no ready. A sample is accepted on every rising edge
  // where in_valid=1 and sclr=0, and is presented exactly LATENCY edges later with out_valid=1.

  localparam int VW = LANES * OUT_WIDTH;

  logic [VW-1:0] rot_r;
  logic [VW-1:0] rot_i;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [OUT_WIDTH-1:0] r_ext;
    logic signed [OUT_WIDTH-1:0] i_ext;
    logic signed [OUT_WIDTH-1:0] xr;
    logic signed [OUT_WIDTH-1:0] xi;

    // Sign-extend before negating so that -(-2^(DATA_WIDTH-1)) is exact.
    assign r_ext = OUT_WIDTH'($signed(a_r[k*DATA_WIDTH +: DATA_WIDTH]));
    assign i_ext = OUT_WIDTH'($signed(a_i[k*DATA_WIDTH +: DATA_WIDTH]));

    always_comb begin
      xr = r_ext;
      xi = i_ext;
      case (rot)
        2'd0: begin xr = r_ext;  xi = i_ext;  end
        2'd1: begin xr = i_ext;  xi = -r_ext; end
        2'd2: begin xr = -r_ext; xi = -i_ext; end
        default: begin xr = -i_ext; xi = r_ext; end
      endcase
    end

    assign rot_r[k*OUT_WIDTH +: OUT_WIDTH] = xr <<< SHIFT;
    assign rot_i[k*OUT_WIDTH +: OUT_WIDTH] = xi <<< SHIFT;
  end

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] sof_q;
  logic [VW-1:0]      dr_q [LATENCY];
  logic [VW-1:0]      di_q [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sof_q <= '0;
    end else if (sclr) begin
      vld_q <= '0;
      sof_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      sof_q[0] <= in_valid & in_sof;
      for (int n = 1; n < LATENCY; n++) begin
        vld_q[n] <= vld_q[n-1];
        sof_q[n] <= sof_q[n-1];
      end
    end
  end

  // Data stages only advance behind a valid bit, so outputs hold the last result across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < LATENCY; n++) begin
        dr_q[n] <= '0;
        di_q[n] <= '0;
      end
    end else begin
      if (in_valid && !sclr) begin
        dr_q[0] <= rot_r;
        di_q[0] <= rot_i;
      end
      for (int n = 1; n < LATENCY; n++) begin
        if (vld_q[n-1]) begin
          dr_q[n] <= dr_q[n-1];
          di_q[n] <= di_q[n-1];
        end
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_sof   = sof_q[LATENCY-1];
  assign b_r       = dr_q[LATENCY-1];
  assign b_i       = di_q[LATENCY-1];
  assign busy      = |vld_q;

endmodule
